seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential radix-2 restoring divider for unsigned operands. It retires one
// quotient bit per clock. It is the exact reference and low-area fallback for
// the Goldschmidt path of the fixed-point divider datapath.
//
// Build option:
//   SEQ_DIVIDER_FRAC_EN  defined   -> fractional mode, 2*WIDTH iterations,
//                                     q = floor(a * 2^WIDTH / b)  (Q(W).(W)),
//                                     r = (a * 2^WIDTH) mod b
//                        undefined -> integer mode, WIDTH iterations,
//                                     q = {WIDTH'b0, floor(a / b)},
//                                     r = a mod b
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   division request, sampled on the rising edge
//   a            in   [WIDTH-1:0]   dividend (unsigned)
//   b            in   [WIDTH-1:0]   divisor (unsigned)
//   busy         out  high while iterations are running
//   done         out  one-cycle pulse; q/r/div_by_zero are valid from it on
//   q            out  [2*WIDTH-1:0] quotient (registered)
//   r            out  [WIDTH-1:0]   remainder (registered)
//   div_by_zero  out  result being presented came from b == 0
//
// Handshake: start is a request sampled on the rising edge and is accepted
// whenever the divider is not busy (IDLE or DONE), so start held high launches
// back-to-back divisions. While busy, start is ignored and a/b are not
// re-latched. Each accepted request yields exactly one done pulse unless rst
// intervenes. q, r and div_by_zero hold their value until the next done.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] q,
    output logic [WIDTH-1:0]   r,
    output logic               div_by_zero
);

`ifdef SEQ_DIVIDER_FRAC_EN
    localparam int NI = 2 * WIDTH;
`else
    localparam int NI = WIDTH;
`endif
    localparam int CW = $clog2(NI + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CW-1:0]    cnt;      // iterations still to run
    logic [WIDTH-1:0] pr;       // partial remainder; always < b, so the
                                // top bit of the WIDTH+1-bit value is zero
    logic [NI-1:0]    sh;       // dividend bits out at the top, quotient in
    logic [WIDTH-1:0] b_q;      // latched divisor

    logic             accept;
    logic             b_zero;
    logic             last;
    logic [WIDTH:0]   pr_sh;    // WIDTH+1-bit trial remainder
    logic             ge;
    logic [WIDTH-1:0] pr_nxt;
    logic [NI-1:0]    sh_nxt;
    logic [NI-1:0]    sh_load;
    logic [2*WIDTH-1:0] q_ext;

    assign accept = start && (state != S_RUN);
    assign b_zero = (b == '0);
    assign last   = (cnt == CW'(1));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign pr_sh  = {pr, sh[NI-1]};
    assign ge     = (pr_sh >= {1'b0, b_q});
    // When ge is false pr_sh < b, so its top bit is zero and truncation is safe.
    assign pr_nxt = ge ? WIDTH'(pr_sh - {1'b0, b_q}) : pr_sh[WIDTH-1:0];
    assign sh_nxt = {sh[NI-2:0], ge};

`ifdef SEQ_DIVIDER_FRAC_EN
    assign sh_load = {a, {WIDTH{1'b0}}};
    assign q_ext   = sh_nxt;
`else
    assign sh_load = a;
    assign q_ext   = {{WIDTH{1'b0}}, sh_nxt};
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = b_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_nxt = b_zero ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pr          <= '0;
            sh          <= '0;
            b_q         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            b_q <= b;
            pr  <= '0;
            sh  <= sh_load;
            if (b_zero) begin
                // No iterations: the result is published at the accepting edge.
                cnt         <= '0;
                q           <= '1;
                r           <= a;
                div_by_zero <= 1'b1;
            end else begin
                cnt <= CW'(NI);
            end
        end else if (state == S_RUN) begin
            pr  <= pr_nxt;
            sh  <= sh_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
                q           <= q_ext;
                r           <= pr_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed self-checking bench for seq_divider. Expected values are hand
// computed for both the integer build and the SEQ_DIVIDER_FRAC_EN build.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef SEQ_DIVIDER_FRAC_EN
    localparam int NI = 32;
`else
    localparam int NI = 16;
`endif

    // ------------------------------------------------------ clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [15:0] r;
    logic        div_by_zero;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    // ------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // --------------------------------------------------------------- driver
    // Launch one division, optionally poking a conflicting start at relative
    // edge 'poke' (0 disables), then check latency, busy length and result.
    task automatic run_div(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                           input logic [31:0] eq, input logic [15:0] er, input logic edbz,
                           input int elat, input int poke);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);                 // acceptance edge k
        #1;
        start = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (poke != 0 && cycles + 1 == poke) begin
                @(negedge clk);
                a = 16'd3; b = 16'd1; start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(elat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat));
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, {16'd0, r}, {16'd0, er});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int gap;
        int done_seen;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", {16'd0, r}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SEQ_DIVIDER_FRAC_EN
        run_div("d100_7",  16'd100,  16'd7, 32'h000E4924, 16'd4, 1'b0, NI, 0);
        run_div("d1_3",    16'd1,    16'd3, 32'h00005555, 16'd1, 1'b0, NI, 0);
        run_div("dffff_1", 16'hFFFF, 16'd1, 32'hFFFF0000, 16'd0, 1'b0, NI, 0);
        run_div("d5_9",    16'd5,    16'd9, 32'h00008E38, 16'd8, 1'b0, NI, 0);
`else
        run_div("d100_7",  16'd100,  16'd7, 32'h0000000E, 16'd2, 1'b0, NI, 0);
        run_div("d1_3",    16'd1,    16'd3, 32'h00000000, 16'd1, 1'b0, NI, 0);
        run_div("dffff_1", 16'hFFFF, 16'd1, 32'h0000FFFF, 16'd0, 1'b0, NI, 0);
        run_div("d5_9",    16'd5,    16'd9, 32'h00000000, 16'd5, 1'b0, NI, 0);
`endif
        run_div("d0_5",    16'd0,    16'd5, 32'h00000000, 16'd0, 1'b0, NI, 0);

        // divide by zero: done right after the accepting edge
        run_div("dbz", 16'h1234, 16'd0, 32'hFFFFFFFF, 16'h1234, 1'b1, 0, 0);

        // next valid division clears div_by_zero; a start poked at relative
        // edge 5 with other operands must be ignored
`ifdef SEQ_DIVIDER_FRAC_EN
        run_div("poke", 16'd100, 16'd7, 32'h000E4924, 16'd4, 1'b0, NI, 5);
`else
        run_div("poke", 16'd100, 16'd7, 32'h0000000E, 16'd2, 1'b0, NI, 5);
`endif

        // back-to-back: start held high through DONE
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        gap = 0;
        @(posedge clk);
        #1;
        while (!done && gap < 100) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check("b2b_first_done", {31'd0, done}, 32'd1);
        a = 16'd200;                    // sampled at the DONE edge
        @(posedge clk);
        #1;
        check("b2b_restart_busy", {31'd0, busy}, 32'd1);
        check("b2b_restart_done", {31'd0, done}, 32'd0);
`ifdef SEQ_DIVIDER_FRAC_EN
        check("b2b_q_held", q, 32'h000E4924);
`else
        check("b2b_q_held", q, 32'h0000000E);
`endif
        gap = 1;
        while (!done && gap < 100) begin
            @(posedge clk);
            #1;
            gap++;
        end
        check("b2b_period", 32'(gap), 32'(NI + 1));
`ifdef SEQ_DIVIDER_FRAC_EN
        check("b2b_q", q, 32'h001C9249);
        check("b2b_r", {16'd0, r}, 32'd1);
`else
        check("b2b_q", q, 32'd28);
        check("b2b_r", {16'd0, r}, 32'd4);
`endif
        start = 1'b0;
        repeat (NI + 3) @(posedge clk);
        #1;

        // reset mid-run at relative edge 8
        @(negedge clk);
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_q", q, 32'd0);
        check("midrst_r", {16'd0, r}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < NI + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);

        // divider still works after the abort
`ifdef SEQ_DIVIDER_FRAC_EN
        run_div("post_rst", 16'd5, 16'd9, 32'h00008E38, 16'd8, 1'b0, NI, 0);
`else
        run_div("post_rst", 16'd5, 16'd9, 32'h00000000, 16'd5, 1'b0, NI, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
